// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: fetches the instruction at pc over a req/ack
// handshake, holds it for execute, and forms the next pc from the Branch_Control select.
module pc_sequencer #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter int                     PC_STEP     = 4,
    parameter int                     CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic                   resolve,
    input  logic [1:0]             branch_control_out,
    input  logic [PC_WIDTH-1:0]    branch_offset,
    input  logic [PC_WIDTH-1:0]    reg_target,
    input  logic                   stall,
    input  logic                   halt_req,
    output logic                   halted,
    output logic                   sel_err,
    output logic                   align_err,
    output logic [CNT_WIDTH-1:0]   retired
);

    // Handshake: imem_req stays high with a stable imem_addr until a cycle with imem_ack;
    // an instruction is consumed in a cycle with instr_valid=1, resolve=1 and stall=0.

    typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALTED} state_t;

    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = STEP - PC_WIDTH'(1);

    state_t              state;
    state_t              state_nx;
    logic                accept;
    logic                misaligned;
    logic [PC_WIDTH-1:0] next_pc;

    assign accept = (state == EXEC) && resolve && !stall;

    always_comb begin
        next_pc = pc + STEP;
        case (branch_control_out)
            2'b01:   next_pc = pc + branch_offset;
            2'b10:   next_pc = reg_target;
            default: next_pc = pc + STEP;
        endcase
    end

    // With PC_STEP=1 the mask is zero and nothing is ever misaligned.
    assign misaligned = |(next_pc & ALIGN_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:   state_nx = FETCH;
            FETCH:  if (imem_ack) state_nx = EXEC;
            EXEC: begin
                if (accept) begin
                    if (halt_req || misaligned) state_nx = HALTED;
                    else                        state_nx = FETCH;
                end
            end
            HALTED: state_nx = HALTED;
            default: state_nx = BOOT;
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            instr     <= '0;
            retired   <= '0;
            sel_err   <= 1'b0;
            align_err <= 1'b0;
        end else begin
            if ((state == FETCH) && imem_ack) instr <= imem_rdata;
            if (accept) begin
                retired <= retired + CNT_WIDTH'(1);
                if (branch_control_out == 2'b11) sel_err <= 1'b1;
                // pc keeps the last executed instruction when the sequencer stops.
                if (!halt_req) begin
                    if (misaligned) align_err <= 1'b1;
                    else            pc        <= next_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: a reference model predicts fetch addresses and
// instruction words, a monitor checks them as handshakes complete.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        resolve = 1'b0;
    logic [1:0]  branch_control_out = 2'b00;
    logic [31:0] branch_offset = '0;
    logic [31:0] reg_target = '0;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        sel_err;
    logic        align_err;
    logic [31:0] retired;

    pc_sequencer #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .PC_STEP(4), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .resolve(resolve), .branch_control_out(branch_control_out),
        .branch_offset(branch_offset), .reg_target(reg_target),
        .stall(stall), .halt_req(halt_req),
        .halted(halted), .sel_err(sel_err), .align_err(align_err), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view only.
    logic [31:0] m_pc;
    logic [31:0] m_retired;
    logic        m_halted, m_sel_err, m_align_err;
    logic [31:0] exp_q[$];
    logic [31:0] instr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a fetch or consumes an instruction.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            if (exp_q.size() == 0) check("unexpected_fetch", 64'(imem_addr), 64'hDEAD);
            else                   check("fetch_addr", 64'(imem_addr), 64'(exp_q.pop_front()));
        end
        if (rst_n && instr_valid && resolve && !stall) begin
            if (instr_q.size() == 0) check("unexpected_accept", 64'(instr), 64'hDEAD);
            else                     check("instr", 64'(instr), 64'(instr_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        m_retired = '0;
        m_halted = 1'b0;
        m_sel_err = 1'b0;
        m_align_err = 1'b0;
        exp_q.delete();
        instr_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"}, 64'(pc), 64'(m_pc));
        check({tag, "_retired"}, 64'(retired), 64'(m_retired));
        check({tag, "_halted"}, 64'(halted), 64'(m_halted));
        check({tag, "_sel_err"}, 64'(sel_err), 64'(m_sel_err));
        check({tag, "_align_err"}, 64'(align_err), 64'(m_align_err));
        check({tag, "_req"}, 64'(imem_req), 64'(!m_halted));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        resolve = 1'b0;
        stall = 1'b0;
        halt_req = 1'b0;
        model_reset();
        step();
        step();
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", 64'(pc), 64'(RST_PC));
        check("rst_flags", 64'({halted, sel_err, align_err}), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        rst_n = 1'b1;
        check("boot_req", 64'(imem_req), 64'd0);
        step();
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", 64'(imem_addr), 64'(RST_PC));
    endtask

    // Waits for the request, keeps ack low for 'delay' cycles (checking a stable request
    // while junk arrives on the execute-side inputs), then acks with 'data'.
    task automatic do_fetch(input int delay, input logic [31:0] data);
        int waited = 0;
        exp_q.push_back(m_pc);
        instr_q.push_back(data);
        while (!imem_req && waited < 20) begin
            step();
            waited++;
        end
        if (!imem_req) check("req_timeout", 64'(imem_req), 64'd1);
        for (int i = 0; i < delay; i++) begin
            check("req_hold", 64'(imem_req), 64'd1);
            check("addr_hold", 64'(imem_addr), 64'(m_pc));
            resolve = 1'($urandom_range(0, 1));
            halt_req = 1'($urandom_range(0, 1));
            branch_control_out = 2'($urandom_range(0, 3));
            step();
        end
        resolve = 1'b0;
        halt_req = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = data;
        step();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        check("exec_valid", 64'(instr_valid), 64'd1);
        check("exec_req", 64'(imem_req), 64'd0);
    endtask

    task automatic do_resolve(input logic [1:0] sel, input logic [31:0] ofs,
                              input logic [31:0] tgt, input logic halt, input int stalls);
        logic [31:0] target;
        for (int i = 0; i < stalls; i++) begin
            resolve = 1'b1;
            stall = 1'b1;
            branch_control_out = 2'($urandom_range(0, 3));
            halt_req = 1'($urandom_range(0, 1));
            step();
            check("stall_pc", 64'(pc), 64'(m_pc));
            check("stall_retired", 64'(retired), 64'(m_retired));
            check("stall_valid", 64'(instr_valid), 64'd1);
        end
        resolve = 1'b1;
        stall = 1'b0;
        branch_control_out = sel;
        branch_offset = ofs;
        reg_target = tgt;
        halt_req = halt;
        m_retired = m_retired + 32'd1;
        if (sel == 2'b01)      target = m_pc + ofs;
        else if (sel == 2'b10) target = tgt;
        else                   target = m_pc + 32'd4;
        if (sel == 2'b11) m_sel_err = 1'b1;
        if (halt) begin
            m_halted = 1'b1;
        end else if (target % 4 != 0) begin
            m_align_err = 1'b1;
            m_halted = 1'b1;
        end else begin
            m_pc = target;
        end
        step();
        resolve = 1'b0;
        halt_req = 1'b0;
        check("post_valid", 64'(instr_valid), 64'd0);
        check_state("resolve");
    endtask

    task automatic check_stays_halted(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_ack = 1'b1;
            resolve = 1'b1;
            branch_control_out = 2'($urandom_range(0, 3));
            step();
            check("halt_req_low", 64'(imem_req), 64'd0);
            check("halt_flag", 64'(halted), 64'd1);
            check("halt_pc", 64'(pc), 64'(m_pc));
        end
        imem_ack = 1'b0;
        resolve = 1'b0;
        check("halt_retired", 64'(retired), 64'(m_retired));
    endtask

    initial begin
        do_reset();

        // Sequential run 0x100..0x10C.
        for (int i = 0; i < 4; i++) begin
            do_fetch($urandom_range(0, 2), $urandom);
            do_resolve(2'b00, '0, '0, 1'b0, 0);
        end
        check("seq_retired", 64'(retired), 64'd4);
        check("seq_pc", 64'(pc), 64'h110);

        // Backwards PC-relative branches, then register target.
        do_fetch(0, $urandom);
        do_resolve(2'b01, 32'hFFFF_FFF8, '0, 1'b0, 0);
        do_fetch(1, $urandom);
        do_resolve(2'b01, 32'hFFFF_FFF8, '0, 1'b0, 0);
        check("branch_back_pc", 64'(pc), 64'h100);
        do_fetch(0, $urandom);
        do_resolve(2'b10, '0, 32'h2000, 1'b0, 0);
        check("reg_target_pc", 64'(pc), 64'h2000);

        // Stall hold and slow memory.
        do_fetch(5, $urandom);
        do_resolve(2'b00, '0, '0, 1'b0, 3);

        // Reserved select: sticky flag, sequential advance.
        do_fetch(0, $urandom);
        do_resolve(2'b11, $urandom, $urandom, 1'b0, 0);
        check("sel11_pc", 64'(pc), 64'h2008);

        // Random aligned traffic.
        for (int i = 0; i < 25; i++) begin
            do_fetch($urandom_range(0, 3), $urandom);
            do_resolve(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
                       $urandom & 32'hFFFF_FFFC, 1'b0, $urandom_range(0, 2));
        end

        // Address wrap-around.
        do_fetch(0, $urandom);
        do_resolve(2'b10, '0, 32'hFFFF_FFFC, 1'b0, 0);
        do_fetch(0, $urandom);
        do_resolve(2'b00, '0, '0, 1'b0, 0);
        check("wrap_pc", 64'(pc), 64'h0);
        do_fetch(0, $urandom);

        // Misaligned register target halts with pc held.
        do_resolve(2'b10, '0, 32'h2002, 1'b0, 0);
        check_stays_halted(4);

        // Reset while a fetch is outstanding; a late ack must be ignored.
        do_reset();
        step();
        step();
        #2;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hA5A5_A5A5;
        #1;
        check("async_req_drop", 64'(imem_req), 64'd0);
        model_reset();
        step();
        rst_n = 1'b1;
        check("late_ack_boot_req", 64'(imem_req), 64'd0);
        step();
        imem_ack = 1'b0;
        check("refetch_req", 64'(imem_req), 64'd1);
        check("refetch_addr", 64'(imem_addr), 64'(RST_PC));
        check("late_ack_instr", 64'(instr), 64'd0);

        // Halt request stops after the current instruction.
        do_fetch(1, $urandom);
        do_resolve(2'b00, '0, '0, 1'b0, 0);
        do_fetch(0, $urandom);
        do_resolve(2'b10, '0, 32'h4000, 1'b1, 1);
        check("halt_pc_held", 64'(pc), 64'h104);
        check_stays_halted(4);

        check("fetch_q_empty", 64'(exp_q.size()), 64'd0);
        check("instr_q_empty", 64'(instr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
